// File: rtl/op_lut_pkg.sv
// Shared definitions for the output-port-lookup forwarding engine:
// FSM states, decision cause codes and Ethernet/IP header field offsets.
package op_lut_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StFwdHdr,
      StSend,
      StDrop
   } state_e;

   // Decision cause codes, reported as a 4-bit index on cause
   localparam logic [3:0] CauseFromCpu   = 4'd0;
   localparam logic [3:0] CauseNotForUs  = 4'd1;
   localparam logic [3:0] CauseNotIp     = 4'd2;
   localparam logic [3:0] CauseBadCsum   = 4'd3;
   localparam logic [3:0] CauseDestIpHit = 4'd4;
   localparam logic [3:0] CauseBadTtl    = 4'd5;
   localparam logic [3:0] CauseIpOptions = 4'd6;
   localparam logic [3:0] CauseLpmMiss   = 4'd7;
   localparam logic [3:0] CauseArpMiss   = 4'd8;
   localparam logic [3:0] CauseBcastDrop = 4'd9;
   localparam logic [3:0] CauseFwd       = 4'd10;
   localparam logic [3:0] CauseBcastCpu  = 4'd11;

   // Field positions within the first beat of a packet
   localparam int unsigned MacWidth  = 48;
   localparam int unsigned EthDstLsb = 0;
   localparam int unsigned EthSrcLsb = 48;
   localparam int unsigned IpTtlLsb  = 176;
   localparam int unsigned IpCsumLsb = 192;

endpackage

// File: rtl/op_lut_src_mac_sel.sv
// Source MAC selection: the MAC of the lowest-numbered MAC port whose queue
// bit (2i) is set in output_port. CPU queue bits are ignored; when no MAC
// queue bit is set, port 0's address is used.
module op_lut_src_mac_sel
   import op_lut_pkg::*;
#(
   parameter int unsigned NUM_PORTS = 4
) (
   input  logic [2*NUM_PORTS-1:0]        output_port,
   input  logic [MacWidth*NUM_PORTS-1:0] mac_table,
   output logic [MacWidth-1:0]           src_mac
);

   // Scan from the top down so the lowest set MAC queue bit wins
   always_comb begin
      src_mac = mac_table[MacWidth-1:0];
      for (int i = NUM_PORTS - 1; i >= 0; i--) begin
         if (output_port[2*i]) src_mac = mac_table[MacWidth*i +: MacWidth];
      end
   end

endmodule

// File: rtl/op_lut_fwd_engine.sv
// Output-port-lookup forwarding engine: takes the preprocess decision flags for
// the packet at the head of the input FIFO, picks a destination (forward, CPU
// or drop), rewrites the Ethernet/IP header on forwarded packets and streams
// the packet out through a registered AXI4-Stream master.
// Optional feature: define OP_LUT_BCAST_FWD_EN to send valid IP broadcasts to
// the CPU (cause 11) instead of dropping them (cause 9).
module op_lut_fwd_engine
   import op_lut_pkg::*;
#(
   parameter int unsigned C_S_AXIS_DATA_WIDTH  = 256,
   parameter int unsigned C_S_AXIS_TUSER_WIDTH = 128,
   parameter int unsigned NUM_PORTS            = 4,
   parameter int unsigned C_DST_PORT_POS       = 24
) (
   input  logic                              clk,
   input  logic                              reset,
   // Input FIFO head (fall-through)
   input  logic                              in_fifo_vld,
   input  logic [C_S_AXIS_DATA_WIDTH-1:0]    in_fifo_tdata,
   input  logic                              in_fifo_tlast,
   input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   in_fifo_tuser,
   input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  in_fifo_tstrb,
   output logic                              in_fifo_rd_en,
   // Preprocess results
   input  logic                              preprocess_vld,
   output logic                              rd_preprocess_info,
   input  logic                              is_from_cpu,
   input  logic                              is_for_us,
   input  logic                              port_match,
   input  logic                              is_broadcast,
   input  logic                              is_ip_pkt,
   input  logic                              ip_checksum_is_good,
   input  logic                              ip_hdr_has_options,
   input  logic                              ip_ttl_is_good,
   input  logic                              dest_ip_hit,
   input  logic                              lpm_lookup_hit,
   input  logic                              arp_lookup_hit,
   input  logic [2*NUM_PORTS-1:0]            output_port,
   input  logic [2*NUM_PORTS-1:0]            to_cpu_output_port,
   input  logic [2*NUM_PORTS-1:0]            from_cpu_output_port,
   input  logic [47:0]                       next_hop_mac,
   input  logic [7:0]                        ip_new_ttl,
   input  logic [15:0]                       ip_new_checksum,
   input  logic [48*NUM_PORTS-1:0]           mac_table,
   // AXI4-Stream master
   output logic                              out_tvalid,
   output logic [C_S_AXIS_DATA_WIDTH-1:0]    out_tdata,
   output logic                              out_tlast,
   output logic [C_S_AXIS_TUSER_WIDTH-1:0]   out_tuser,
   output logic [C_S_AXIS_DATA_WIDTH/8-1:0]  out_tstrb,
   input  logic                              out_tready,
   // Decision report
   output logic [3:0]                        cause,
   output logic                              cause_vld
);

   localparam int unsigned NUM_QUEUES = 2 * NUM_PORTS;
   localparam int unsigned DW         = C_S_AXIS_DATA_WIDTH;
   localparam int unsigned UW         = C_S_AXIS_TUSER_WIDTH;
   localparam int unsigned SW         = C_S_AXIS_DATA_WIDTH / 8;

   state_e                state_q, state_d;
   logic [NUM_QUEUES-1:0] dst_port_q, dst_port_d;
   logic [3:0]            cause_q, cause_d;
   logic [MacWidth-1:0]   src_mac_q, src_mac_d;
   logic [MacWidth-1:0]   next_hop_q, next_hop_d;
   logic [7:0]            new_ttl_q, new_ttl_d;
   logic [15:0]           new_csum_q, new_csum_d;
   logic                  out_tvalid_q, out_tvalid_d;
   logic [DW-1:0]         out_tdata_q, out_tdata_d;
   logic                  out_tlast_q, out_tlast_d;
   logic [UW-1:0]         out_tuser_q, out_tuser_d;
   logic [SW-1:0]         out_tstrb_q, out_tstrb_d;

   state_e                dec_state;
   logic [NUM_QUEUES-1:0] dec_dst;
   logic [3:0]            dec_cause;
   logic [MacWidth-1:0]   sel_src_mac;
   logic                  decide;
   logic                  advance;
   logic [DW-1:0]         beat_tdata;
   logic [UW-1:0]         beat_tuser;

   op_lut_src_mac_sel #(
      .NUM_PORTS (NUM_PORTS)
   ) u_src_mac_sel (
      .output_port (output_port),
      .mac_table   (mac_table),
      .src_mac     (sel_src_mac)
   );

   // Prioritised packet decision; the first matching check wins
   always_comb begin
      dec_state = StSend;
      dec_dst   = to_cpu_output_port;
      dec_cause = CauseNotIp;
      if (is_from_cpu) begin
         dec_dst   = from_cpu_output_port;
         dec_cause = CauseFromCpu;
      end else if (!(is_for_us && (port_match || is_broadcast))) begin
         dec_state = StDrop;
         dec_dst   = '0;
         dec_cause = CauseNotForUs;
      end else if (!is_ip_pkt) begin
         dec_cause = CauseNotIp;
      end else if (!ip_checksum_is_good) begin
         dec_state = StDrop;
         dec_dst   = '0;
         dec_cause = CauseBadCsum;
      end else if (dest_ip_hit) begin
         dec_cause = CauseDestIpHit;
      end else if (!ip_ttl_is_good) begin
         dec_cause = CauseBadTtl;
      end else if (ip_hdr_has_options) begin
         dec_cause = CauseIpOptions;
      end else if (!lpm_lookup_hit) begin
         dec_cause = CauseLpmMiss;
      end else if (!arp_lookup_hit) begin
         dec_cause = CauseArpMiss;
      end else if (is_broadcast) begin
`ifdef OP_LUT_BCAST_FWD_EN
         dec_cause = CauseBcastCpu;
`else
         dec_state = StDrop;
         dec_dst   = '0;
         dec_cause = CauseBcastDrop;
`endif
      end else begin
         dec_state = StFwdHdr;
         dec_dst   = output_port;
         dec_cause = CauseFwd;
      end
   end

   // Handshakes: decision pulses, FIFO pop and output-register advance
   always_comb begin
      decide             = !reset && (state_q == StIdle) && preprocess_vld;
      rd_preprocess_info = decide;
      cause_vld          = decide;
      cause              = decide ? dec_cause : cause_q;
      advance            = !out_tvalid_q || out_tready;
      in_fifo_rd_en      = 1'b0;
      if (!reset && in_fifo_vld) begin
         if (state_q == StDrop) begin
            // Dropped beats never reach the output, so backpressure is irrelevant
            in_fifo_rd_en = 1'b1;
         end else if ((state_q == StFwdHdr) || (state_q == StSend)) begin
            in_fifo_rd_en = advance;
         end
      end
   end

   // Beat as it will be emitted: destination tagged, header rewritten on FWD_HDR
   always_comb begin
      beat_tuser = in_fifo_tuser;
      beat_tuser[C_DST_PORT_POS +: NUM_QUEUES] = dst_port_q;
      beat_tdata = in_fifo_tdata;
      if (state_q == StFwdHdr) begin
         beat_tdata[EthDstLsb +: MacWidth] = next_hop_q;
         beat_tdata[EthSrcLsb +: MacWidth] = src_mac_q;
         beat_tdata[IpTtlLsb +: 8]         = new_ttl_q;
         beat_tdata[IpCsumLsb +: 16]       = new_csum_q;
      end
   end

   // Next-state logic for the FSM, latched decision and output register
   always_comb begin
      state_d      = state_q;
      dst_port_d   = dst_port_q;
      cause_d      = cause_q;
      src_mac_d    = src_mac_q;
      next_hop_d   = next_hop_q;
      new_ttl_d    = new_ttl_q;
      new_csum_d   = new_csum_q;
      out_tvalid_d = out_tvalid_q;
      out_tdata_d  = out_tdata_q;
      out_tlast_d  = out_tlast_q;
      out_tuser_d  = out_tuser_q;
      out_tstrb_d  = out_tstrb_q;

      if (advance) out_tvalid_d = 1'b0;

      case (state_q)
         StIdle: begin
            if (decide) begin
               state_d    = dec_state;
               dst_port_d = dec_dst;
               cause_d    = dec_cause;
               // Preprocess results are popped now, so keep what FWD_HDR needs
               src_mac_d  = sel_src_mac;
               next_hop_d = next_hop_mac;
               new_ttl_d  = ip_new_ttl;
               new_csum_d = ip_new_checksum;
            end
         end
         StFwdHdr, StSend: begin
            if (in_fifo_rd_en) begin
               out_tvalid_d = 1'b1;
               out_tdata_d  = beat_tdata;
               out_tlast_d  = in_fifo_tlast;
               out_tuser_d  = beat_tuser;
               out_tstrb_d  = in_fifo_tstrb;
               state_d      = in_fifo_tlast ? StIdle : StSend;
            end
         end
         StDrop: begin
            if (in_fifo_rd_en && in_fifo_tlast) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // State and output registers with synchronous active-high reset
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= StIdle;
         dst_port_q   <= '0;
         cause_q      <= '0;
         src_mac_q    <= '0;
         next_hop_q   <= '0;
         new_ttl_q    <= '0;
         new_csum_q   <= '0;
         out_tvalid_q <= 1'b0;
         out_tdata_q  <= '0;
         out_tlast_q  <= 1'b0;
         out_tuser_q  <= '0;
         out_tstrb_q  <= '0;
      end else begin
         state_q      <= state_d;
         dst_port_q   <= dst_port_d;
         cause_q      <= cause_d;
         src_mac_q    <= src_mac_d;
         next_hop_q   <= next_hop_d;
         new_ttl_q    <= new_ttl_d;
         new_csum_q   <= new_csum_d;
         out_tvalid_q <= out_tvalid_d;
         out_tdata_q  <= out_tdata_d;
         out_tlast_q  <= out_tlast_d;
         out_tuser_q  <= out_tuser_d;
         out_tstrb_q  <= out_tstrb_d;
      end
   end

   assign out_tvalid = out_tvalid_q;
   assign out_tdata  = out_tdata_q;
   assign out_tlast  = out_tlast_q;
   assign out_tuser  = out_tuser_q;
   assign out_tstrb  = out_tstrb_q;

endmodule
